pic_priority_engine: RTL and testbench
======================================

Name: pic_priority_engine

Overview:
Parametrised, clocked interrupt priority engine for the PIC datapath, with N request channels. It owns the IRR and ISR registers, the rotating priority pointer, the two-pulse INTA acknowledge state machine and EOI handling. It sits between the request-edge inputs and the control/bus logic, and drives INT plus the acknowledged channel ID.

Parameters:
NUM_IRQ, 8, number of request channels (2..32; need not be a power of two)
IDX_W, $clog2(NUM_IRQ), channel index width (derived localparam, not overridable)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
irq_in  in  NUM_IRQ  raw request lines, already synchronised
level_mode  in  1  1 = level-triggered, 0 = rising-edge-triggered
imr  in  NUM_IRQ  interrupt mask register
special_mask_mode  in  1  masked ISR bits do not block lower priorities
auto_eoi  in  1  ISR bit is not retained after acknowledge
auto_rotate  in  1  rotate priority on auto-EOI or on non-specific EOI
eoi_valid  in  1  one-cycle EOI command strobe
eoi_specific  in  1  1 = clear eoi_level, 0 = clear highest-priority ISR bit
eoi_level  in  IDX_W  target channel for specific EOI
eoi_rotate  in  1  rotate priority on this EOI
set_prio_valid  in  1  one-cycle strobe: set lowest-priority channel
set_prio_level  in  IDX_W  new lowest-priority channel
inta  in  1  one-cycle pulse per INTA bus phase
int_out  out  1  interrupt request to CPU (registered)
ack_valid  out  1  one-cycle pulse: acknowledge complete
ack_id  out  IDX_W  acknowledged channel
ack_spurious  out  1  qualifies ack_valid: no real source
irr  out  NUM_IRQ  IRR status
isr  out  NUM_IRQ  ISR status
lowest_prio  out  IDX_W  current lowest-priority channel

Behaviour:
- Reset (async): irr, isr, edge history = 0; lowest_prio = NUM_IRQ-1; FSM = IDLE; int_out, ack_valid, ack_spurious = 0; ack_id = 0.
- Request capture:
  - Edge mode: IRR bit is set on a 0→1 transition of irq_in versus its registered previous value.
  - Level mode: IRR bit is set while irq_in is high and cleared when irq_in goes low before the acknowledge.
- Priority order: channel (lowest_prio+1) mod NUM_IRQ is highest, continuing upward with modulo wrap. Wrap must be explicit when NUM_IRQ is not a power of two.
- Candidate: highest-priority bit of irr & ~imr.
- Blocking set: isr, or isr & ~imr when special_mask_mode = 1.
- The candidate is blocked if any bit of the blocking set is at equal or higher priority.
- int_out is registered: 1 cycle after (candidate present & not blocked & FSM == IDLE).
- FSM IDLE→ACK1 on inta:
  - Freeze the candidate index into frozen_id, ignoring blocking state.
  - If there is no candidate: frozen_id = NUM_IRQ-1 and the spurious flag is set.
  - int_out drops next cycle and is held 0 until the FSM returns to IDLE.
- FSM ACK1→IDLE on the second inta:
  - Clear irr[frozen_id].
  - Set isr[frozen_id] unless auto_eoi or spurious.
  - If auto_eoi & auto_rotate & !spurious: lowest_prio = frozen_id.
  - Next cycle: ack_valid = 1, ack_id = frozen_id, ack_spurious = flag.
  - A spurious acknowledge changes no IRR, ISR or priority state.
- EOI (any FSM state):
  - Non-specific: clear the highest-priority bit of the blocking set.
  - Specific: clear isr[eoi_level].
  - Rotation on the cleared level L: lowest_prio = L if eoi_rotate, or if auto_rotate and the EOI is non-specific.
  - Non-specific EOI with an empty blocking set: no-op, no rotation.
- set_prio_valid: lowest_prio = set_prio_level.
- Same cycle set_prio_valid + rotating EOI: set_prio wins the pointer; the ISR clear still happens.
- Same cycle EOI clear + ACK2 set on the same bit: the set wins.
- Same cycle irq edge + ACK2 clear on the same bit: the clear wins; the edge is lost.
- An index ≥ NUM_IRQ on eoi_level or set_prio_level is ignored.
- Reset asserted mid-acknowledge: immediate return to IDLE; no ack_valid.

Optional Feature:
PIC_POLL_EN
- Compiled in: adds input poll_rd (1) and output poll_data (IDX_W+1).
- A poll_rd pulse in IDLE acts as a complete acknowledge in one step, using the same ISR/IRR/rotation rules.
- The next cycle, poll_data = {pending, id}; pending = 0 means no candidate, and no state changes.
- Compiled out: these ports and this logic are absent.

Decomposition:
- Package pic_pkg holds:
  - FSM state enum: IDLE, ACK1.
  - RESET_LOWEST_PRIO helper function.
  - Modulo-add index function shared by pointer math.
- Sub-module pic_priority_pick: combinational rotating find-highest over NUM_IRQ bits; inputs vec and lowest_prio; outputs found and idx.
  - Instantiated twice: once for the candidate, once for the non-specific EOI target and the blocking check.

Test Plan:
- NUM_IRQ=8, edge mode, pulse irq_in[3] → int_out=1 within 2 cycles; two inta pulses → ack_valid with ack_id=3, isr=0x08, irr=0.
- isr[2] set, raise irq_in[5] → int_out stays 0; raise irq_in[1] → int_out=1; non-specific EOI clears isr[2].
- auto_rotate=1, ack then non-specific EOI on IR4 → lowest_prio=4; simultaneous irq 4 and 5 → next ack_id=5.
- inta with no request pending → ack_spurious=1, ack_id=7, isr unchanged.
- NUM_IRQ=5, set_prio_level=4, requests 0 and 3 → ack_id=0 (wrap); set_prio_level=7 → ignored.
- special_mask_mode=1, imr[1]=1, isr[1]=1, irq_in[6] → int_out=1, ack_id=6.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and index arithmetic for the PIC priority engine.
package pic_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      ACK1 = 1'b1
   } pic_state_e;

   // Lowest-priority channel after reset: the top channel, so channel 0 ranks highest.
   function automatic int unsigned reset_lowest_prio(input int unsigned num_irq);
      return num_irq - 1;
   endfunction

   // (a + b) mod n for a < n and b <= n. The wrap is explicit, so n need not be a power of two.
   function automatic int unsigned mod_add(input int unsigned a, input int unsigned b,
                                           input int unsigned n);
      int unsigned s;
      s = a + b;
      return (s >= n) ? s - n : s;
   endfunction

   function automatic logic idx_in_range(input int unsigned idx, input int unsigned n);
      return idx < n;
   endfunction

endpackage

// File: rtl/pic_priority_pick.sv
// Rotating find-highest: returns the set bit of vec that ranks highest when channel
// (lowest_prio+1) mod NUM_IRQ has top priority.
module pic_priority_pick
   import pic_pkg::*;
#(
   parameter  int NUM_IRQ = 8,
   localparam int IDX_W   = $clog2(NUM_IRQ)
) (
   input  logic [NUM_IRQ-1:0] vec,
   input  logic [IDX_W-1:0]   lowest_prio,
   output logic               found,
   output logic [IDX_W-1:0]   idx
);

   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      // Walk from lowest to highest priority; the last hit is the winner.
      for (int k = NUM_IRQ; k >= 1; k--) begin
         logic [IDX_W-1:0] ch;
         ch = IDX_W'(mod_add(32'(lowest_prio), k, NUM_IRQ));
         if (vec[ch]) begin
            found = 1'b1;
            idx   = ch;
         end
      end
   end

endmodule

// File: rtl/pic_priority_engine.sv
// PIC priority engine: IRR/ISR, rotating priority, two-pulse INTA handshake, EOI.
// Optional `PIC_POLL_EN adds poll_rd / poll_data (poll acts as a one-step acknowledge).
module pic_priority_engine
   import pic_pkg::*;
#(
   parameter  int NUM_IRQ = 8,
   localparam int IDX_W   = $clog2(NUM_IRQ)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               level_mode,
   input  logic [NUM_IRQ-1:0] imr,
   input  logic               special_mask_mode,
   input  logic               auto_eoi,
   input  logic               auto_rotate,
   input  logic               eoi_valid,
   input  logic               eoi_specific,
   input  logic [IDX_W-1:0]   eoi_level,
   input  logic               eoi_rotate,
   input  logic               set_prio_valid,
   input  logic [IDX_W-1:0]   set_prio_level,
   input  logic               inta,
`ifdef PIC_POLL_EN
   input  logic               poll_rd,
   output logic [IDX_W:0]     poll_data,
`endif
   output logic               int_out,
   output logic               ack_valid,
   output logic [IDX_W-1:0]   ack_id,
   output logic               ack_spurious,
   output logic [NUM_IRQ-1:0] irr,
   output logic [NUM_IRQ-1:0] isr,
   output logic [IDX_W-1:0]   lowest_prio
);

   pic_state_e         state_q, state_d;
   logic [NUM_IRQ-1:0] irr_q, irr_d, isr_q, isr_d, irq_prev_q, blk_set;
   logic [IDX_W-1:0]   lowest_q, lowest_d, frozen_q, frozen_d, ack_id_q, ack_id_d;
   logic [IDX_W-1:0]   cand_idx, blk_idx, ack_idx;
   logic               spur_q, spur_d, int_q, int_d;
   logic               ack_valid_q, ack_valid_d, ack_spur_q, ack_spur_d;
   logic               cand_found, blk_found, blocked, poll_go, do_ack, ack_real;
   logic [31:0]        rank_off, cand_rank, blk_rank;

   assign blk_set = special_mask_mode ? (isr_q & ~imr) : isr_q;

   pic_priority_pick #(.NUM_IRQ(NUM_IRQ)) u_cand_pick (
      .vec         (irr_q & ~imr),
      .lowest_prio (lowest_q),
      .found       (cand_found),
      .idx         (cand_idx)
   );

   pic_priority_pick #(.NUM_IRQ(NUM_IRQ)) u_blk_pick (
      .vec         (blk_set),
      .lowest_prio (lowest_q),
      .found       (blk_found),
      .idx         (blk_idx)
   );

   // Rank 0 is the highest-priority channel; only the top blocking bit needs comparing.
   assign rank_off  = 32'(NUM_IRQ - 1) - 32'(lowest_q);
   assign cand_rank = mod_add(32'(cand_idx), rank_off, NUM_IRQ);
   assign blk_rank  = mod_add(32'(blk_idx), rank_off, NUM_IRQ);
   assign blocked   = blk_found && (blk_rank <= cand_rank);

`ifdef PIC_POLL_EN
   logic [IDX_W:0] poll_data_q, poll_data_d;

   assign poll_go     = poll_rd;
   assign poll_data_d = {cand_found, cand_found ? cand_idx : {IDX_W{1'b0}}};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         poll_data_q <= '0;
      end else if (poll_go && (state_q == IDLE) && !inta) begin
         poll_data_q <= poll_data_d;
      end
   end

   assign poll_data = poll_data_q;
`else
   assign poll_go = 1'b0;
`endif

   always_comb begin
      irr_d       = level_mode ? irq_in : (irr_q | (irq_in & ~irq_prev_q));
      isr_d       = isr_q;
      lowest_d    = lowest_q;
      state_d     = state_q;
      frozen_d    = frozen_q;
      spur_d      = spur_q;
      ack_valid_d = 1'b0;
      ack_id_d    = ack_id_q;
      ack_spur_d  = ack_spur_q;
      do_ack      = 1'b0;
      ack_idx     = frozen_q;
      ack_real    = 1'b0;
      int_d       = (state_q == IDLE) && !inta && !poll_go && cand_found && !blocked;

      case (state_q)
         IDLE: begin
            if (inta) begin
               state_d  = ACK1;
               frozen_d = cand_found ? cand_idx : IDX_W'(NUM_IRQ - 1);
               spur_d   = !cand_found;
            end else if (poll_go) begin
               do_ack   = 1'b1;
               ack_idx  = cand_idx;
               ack_real = cand_found;
            end
         end
         ACK1: begin
            if (inta) begin
               state_d     = IDLE;
               do_ack      = 1'b1;
               ack_real    = !spur_q;
               ack_valid_d = 1'b1;
               ack_id_d    = frozen_q;
               ack_spur_d  = spur_q;
            end
         end
         default: state_d = IDLE;
      endcase

      // Pointer writers in rising precedence: auto-EOI rotation, EOI rotation, set_prio.
      if (do_ack && ack_real && auto_eoi && auto_rotate) begin
         lowest_d = ack_idx;
      end

      if (eoi_valid) begin
         if (eoi_specific) begin
            if (idx_in_range(32'(eoi_level), NUM_IRQ)) begin
               isr_d[eoi_level] = 1'b0;
               if (eoi_rotate) lowest_d = eoi_level;
            end
         end else if (blk_found) begin
            isr_d[blk_idx] = 1'b0;
            if (eoi_rotate || auto_rotate) lowest_d = blk_idx;
         end
      end

      // Applied after capture and EOI: the acknowledge clear/set wins on the same bit.
      if (do_ack && ack_real) begin
         irr_d[ack_idx] = 1'b0;
         if (!auto_eoi) isr_d[ack_idx] = 1'b1;
      end

      if (set_prio_valid && idx_in_range(32'(set_prio_level), NUM_IRQ)) begin
         lowest_d = set_prio_level;
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         irr_q       <= '0;
         isr_q       <= '0;
         irq_prev_q  <= '0;
         lowest_q    <= IDX_W'(reset_lowest_prio(NUM_IRQ));
         frozen_q    <= '0;
         spur_q      <= 1'b0;
         int_q       <= 1'b0;
         ack_valid_q <= 1'b0;
         ack_id_q    <= '0;
         ack_spur_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         irr_q       <= irr_d;
         isr_q       <= isr_d;
         irq_prev_q  <= irq_in;
         lowest_q    <= lowest_d;
         frozen_q    <= frozen_d;
         spur_q      <= spur_d;
         int_q       <= int_d;
         ack_valid_q <= ack_valid_d;
         ack_id_q    <= ack_id_d;
         ack_spur_q  <= ack_spur_d;
      end
   end

   assign int_out      = int_q;
   assign ack_valid    = ack_valid_q;
   assign ack_id       = ack_id_q;
   assign ack_spurious = ack_spur_q;
   assign irr          = irr_q;
   assign isr          = isr_q;
   assign lowest_prio  = lowest_q;

endmodule

// File: tb/tb_pic_priority_engine.sv
// Self-checking bench for pic_priority_engine: vector table, corner sequences,
// a 5-channel instance for wrap/range cases, and random traffic against a reference model.
module tb_pic_priority_engine;

   localparam int N = 8;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] irq_in, imr, irr, isr;
   logic       level_mode, special_mask_mode, auto_eoi, auto_rotate;
   logic       eoi_valid, eoi_specific, eoi_rotate, set_prio_valid, inta;
   logic [2:0] eoi_level, set_prio_level, ack_id, lowest_prio;
   logic       int_out, ack_valid, ack_spurious;

   logic [4:0] irq5, irr5, isr5;
   logic [2:0] sp_lvl5, eoi_lvl5, ack_id5, low5;
   logic       sp_v5, inta5, eoi_v5, int5, ackv5, acksp5;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

`ifdef PIC_POLL_EN
   logic       poll_rd = 1'b0;
   logic       poll_rd5 = 1'b0;
   logic [3:0] poll_data, poll_data5;
`endif

   pic_priority_engine #(.NUM_IRQ(8)) dut (
      .clock(clock), .reset(reset), .irq_in(irq_in), .level_mode(level_mode), .imr(imr),
      .special_mask_mode(special_mask_mode), .auto_eoi(auto_eoi), .auto_rotate(auto_rotate),
      .eoi_valid(eoi_valid), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
      .eoi_rotate(eoi_rotate), .set_prio_valid(set_prio_valid), .set_prio_level(set_prio_level),
      .inta(inta),
`ifdef PIC_POLL_EN
      .poll_rd(poll_rd), .poll_data(poll_data),
`endif
      .int_out(int_out), .ack_valid(ack_valid), .ack_id(ack_id), .ack_spurious(ack_spurious),
      .irr(irr), .isr(isr), .lowest_prio(lowest_prio)
   );

   pic_priority_engine #(.NUM_IRQ(5)) dut5 (
      .clock(clock), .reset(reset), .irq_in(irq5), .level_mode(1'b0), .imr(5'b0),
      .special_mask_mode(1'b0), .auto_eoi(1'b0), .auto_rotate(1'b0),
      .eoi_valid(eoi_v5), .eoi_specific(1'b1), .eoi_level(eoi_lvl5),
      .eoi_rotate(1'b0), .set_prio_valid(sp_v5), .set_prio_level(sp_lvl5),
      .inta(inta5),
`ifdef PIC_POLL_EN
      .poll_rd(poll_rd5), .poll_data(poll_data5),
`endif
      .int_out(int5), .ack_valid(ackv5), .ack_id(ack_id5), .ack_spurious(acksp5),
      .irr(irr5), .isr(isr5), .lowest_prio(low5)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model (8 channels) ----------------
   logic [7:0] m_irr, m_isr, m_prev;
   int         m_low, m_frozen, m_ackid;
   bit         m_in_ack, m_spur, m_int, m_ackv, m_acksp;

   // Highest-priority set bit, walking upward from lowest+1 with wrap; -1 if none.
   function automatic int top_of(input logic [7:0] v, input int lp);
      for (int k = 1; k <= N; k++) begin
         int ch;
         ch = (lp + k) % N;
         if (v[3'(ch)]) return ch;
      end
      return -1;
   endfunction

   function automatic int rank_of(input int ch, input int lp);
      return (ch - lp - 1 + 2 * N) % N;
   endfunction

   task automatic model_reset();
      m_irr = '0; m_isr = '0; m_prev = '0; m_low = N - 1;
      m_in_ack = 0; m_frozen = 0; m_spur = 0;
      m_int = 0; m_ackv = 0; m_ackid = 0; m_acksp = 0;
   endtask

   task automatic model_step();
      logic [7:0] n_irr, n_isr, blkset;
      int         cand, blk, n_low;
      bit         blocked, acking, n_int;
      blkset  = special_mask_mode ? (m_isr & ~imr) : m_isr;
      cand    = top_of(m_irr & ~imr, m_low);
      blk     = top_of(blkset, m_low);
      blocked = (blk >= 0) && (cand >= 0) && (rank_of(blk, m_low) <= rank_of(cand, m_low));
      n_irr   = level_mode ? irq_in : (m_irr | (irq_in & ~m_prev));
      n_isr   = m_isr;
      n_low   = m_low;
      acking  = m_in_ack && inta;
      n_int   = !m_in_ack && !inta && (cand >= 0) && !blocked;
      if (acking && !m_spur && auto_eoi && auto_rotate) n_low = m_frozen;
      // All 3-bit levels are in range for 8 channels.
      if (eoi_valid) begin
         if (eoi_specific) begin
            n_isr[eoi_level] = 1'b0;
            if (eoi_rotate) n_low = int'(eoi_level);
         end else if (blk >= 0) begin
            n_isr[3'(blk)] = 1'b0;
            if (eoi_rotate || auto_rotate) n_low = blk;
         end
      end
      if (acking && !m_spur) begin
         n_irr[3'(m_frozen)] = 1'b0;
         if (!auto_eoi) n_isr[3'(m_frozen)] = 1'b1;
      end
      if (set_prio_valid) n_low = int'(set_prio_level);
      m_ackv = acking;
      if (acking) begin
         m_ackid = m_frozen;
         m_acksp = m_spur;
         m_in_ack = 0;
      end else if (!m_in_ack && inta) begin
         m_in_ack = 1;
         m_frozen = (cand >= 0) ? cand : N - 1;
         m_spur   = (cand < 0);
      end
      m_int = n_int; m_irr = n_irr; m_isr = n_isr; m_low = n_low; m_prev = irq_in;
   endtask

   task automatic check_model(input string tag);
      check({tag, "/int_out"}, 32'(int_out), 32'(m_int));
      check({tag, "/ack_valid"}, 32'(ack_valid), 32'(m_ackv));
      check({tag, "/irr"}, 32'(irr), 32'(m_irr));
      check({tag, "/isr"}, 32'(isr), 32'(m_isr));
      check({tag, "/lowest_prio"}, 32'(lowest_prio), 32'(m_low));
      if (m_ackv) begin
         check({tag, "/ack_id"}, 32'(ack_id), 32'(m_ackid));
         check({tag, "/ack_spurious"}, 32'(ack_spurious), 32'(m_acksp));
      end
   endtask

   // One clock: model consumes the inputs now applied, DUT samples them at the edge.
   task automatic tick();
      model_step();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse(input logic [7:0] m);
      irq_in = m; tick();
      irq_in = '0; tick();
   endtask

   task automatic do_ack();
      inta = 1'b1; tick();
      inta = 1'b0; tick();
      inta = 1'b1; tick();
      inta = 1'b0;
   endtask

   task automatic eoi_ns();
      eoi_valid = 1'b1; eoi_specific = 1'b0; tick();
      eoi_valid = 1'b0;
   endtask

   typedef struct {
      logic [7:0] irq;
      logic       inta;
      logic       eoi;
      logic       exp_int;
      logic       exp_ackv;
      logic [2:0] exp_id;
      logic [7:0] exp_irr;
      logic [7:0] exp_isr;
   } vec_t;

   vec_t tbl[16];

   initial begin
      // Edge request on IR3 and its acknowledge, then IR5 blocked by ISR2, IR1 not blocked.
      tbl[0]  = '{8'h08, 0, 0, 0, 0, 3'd0, 8'h08, 8'h00};
      tbl[1]  = '{8'h00, 0, 0, 1, 0, 3'd0, 8'h08, 8'h00};
      tbl[2]  = '{8'h00, 1, 0, 0, 0, 3'd0, 8'h08, 8'h00};
      tbl[3]  = '{8'h00, 0, 0, 0, 0, 3'd0, 8'h08, 8'h00};
      tbl[4]  = '{8'h00, 1, 0, 0, 1, 3'd3, 8'h00, 8'h08};
      tbl[5]  = '{8'h00, 0, 0, 0, 0, 3'd0, 8'h00, 8'h08};
      tbl[6]  = '{8'h00, 0, 1, 0, 0, 3'd0, 8'h00, 8'h00};
      tbl[7]  = '{8'h04, 0, 0, 0, 0, 3'd0, 8'h04, 8'h00};
      tbl[8]  = '{8'h00, 0, 0, 1, 0, 3'd0, 8'h04, 8'h00};
      tbl[9]  = '{8'h00, 1, 0, 0, 0, 3'd0, 8'h04, 8'h00};
      tbl[10] = '{8'h00, 1, 0, 0, 1, 3'd2, 8'h00, 8'h04};
      tbl[11] = '{8'h20, 0, 0, 0, 0, 3'd0, 8'h20, 8'h04};
      tbl[12] = '{8'h20, 0, 0, 0, 0, 3'd0, 8'h20, 8'h04};
      tbl[13] = '{8'h22, 0, 0, 0, 0, 3'd0, 8'h22, 8'h04};
      tbl[14] = '{8'h22, 0, 0, 1, 0, 3'd0, 8'h22, 8'h04};
      tbl[15] = '{8'h22, 0, 1, 1, 0, 3'd0, 8'h22, 8'h00};

      reset = 1'b1;
      irq_in = '0; imr = '0; level_mode = 0; special_mask_mode = 0; auto_eoi = 0;
      auto_rotate = 0; eoi_valid = 0; eoi_specific = 0; eoi_level = '0; eoi_rotate = 0;
      set_prio_valid = 0; set_prio_level = '0; inta = 0;
      irq5 = '0; sp_v5 = 0; sp_lvl5 = '0; inta5 = 0; eoi_v5 = 0; eoi_lvl5 = '0;
      model_reset();
      #12;
      check("reset/int_out", 32'(int_out), 32'd0);
      check("reset/ack_valid", 32'(ack_valid), 32'd0);
      check("reset/ack_id", 32'(ack_id), 32'd0);
      check("reset/ack_spurious", 32'(ack_spurious), 32'd0);
      check("reset/irr", 32'(irr), 32'h00);
      check("reset/isr", 32'(isr), 32'h00);
      check("reset/lowest_prio", 32'(lowest_prio), 32'd7);
      check("reset/lowest_prio5", 32'(low5), 32'd4);
      @(posedge clock); #1;
      reset = 1'b0;

      for (int i = 0; i < 16; i++) begin
         irq_in = tbl[i].irq; inta = tbl[i].inta;
         eoi_valid = tbl[i].eoi; eoi_specific = 1'b0;
         tick();
         check($sformatf("vec%0d/int_out", i), 32'(int_out), 32'(tbl[i].exp_int));
         check($sformatf("vec%0d/ack_valid", i), 32'(ack_valid), 32'(tbl[i].exp_ackv));
         if (tbl[i].exp_ackv)
            check($sformatf("vec%0d/ack_id", i), 32'(ack_id), 32'(tbl[i].exp_id));
         check($sformatf("vec%0d/irr", i), 32'(irr), 32'(tbl[i].exp_irr));
         check($sformatf("vec%0d/isr", i), 32'(isr), 32'(tbl[i].exp_isr));
      end
      irq_in = '0; inta = 0; eoi_valid = 0;

      // Reset in the middle of an acknowledge, then a spurious acknowledge.
      inta = 1'b1; tick();
      inta = 1'b0; tick();
      #2 reset = 1'b1;
      #1;
      check("midack_reset/int_out", 32'(int_out), 32'd0);
      check("midack_reset/irr", 32'(irr), 32'h00);
      check("midack_reset/lowest", 32'(lowest_prio), 32'd7);
      model_reset();
      @(posedge clock); #1;
      check("midack_reset/ack_valid", 32'(ack_valid), 32'd0);
      reset = 1'b0;
      do_ack();
      check("spurious/ack_valid", 32'(ack_valid), 32'd1);
      check("spurious/ack_spurious", 32'(ack_spurious), 32'd1);
      check("spurious/ack_id", 32'(ack_id), 32'd7);
      check("spurious/isr", 32'(isr), 32'h00);

      // Auto-rotate on non-specific EOI, then simultaneous IR4 and IR5.
      auto_rotate = 1'b1;
      pulse(8'h10);
      do_ack();
      check("rot/ack_id", 32'(ack_id), 32'd4);
      check("rot/isr", 32'(isr), 32'h10);
      eoi_ns();
      check("rot/isr_cleared", 32'(isr), 32'h00);
      check("rot/lowest_prio", 32'(lowest_prio), 32'd4);
      pulse(8'h30);
      do_ack();
      check("rot/ack_id_after_rotate", 32'(ack_id), 32'd5);
      eoi_ns();
      do_ack();
      eoi_ns();
      check_model("rot_cleanup");
      auto_rotate = 1'b0;

      // Special mask mode: masked in-service IR1 stops blocking IR6.
      set_prio_valid = 1'b1; set_prio_level = 3'd7; tick();
      set_prio_valid = 1'b0;
      check("setprio/lowest", 32'(lowest_prio), 32'd7);
      pulse(8'h02);
      do_ack();
      check("smm/ack_id1", 32'(ack_id), 32'd1);
      imr = 8'h02;
      pulse(8'h40);
      check("smm/blocked_int", 32'(int_out), 32'd0);
      special_mask_mode = 1'b1; tick();
      check("smm/unblocked_int", 32'(int_out), 32'd1);
      do_ack();
      check("smm/ack_id6", 32'(ack_id), 32'd6);
      check("smm/isr", 32'(isr), 32'h42);

      // set_prio and a rotating specific EOI together: pointer from set_prio, ISR still cleared.
      eoi_valid = 1; eoi_specific = 1; eoi_level = 3'd6; eoi_rotate = 1;
      set_prio_valid = 1; set_prio_level = 3'd2;
      tick();
      eoi_valid = 0; eoi_rotate = 0; set_prio_valid = 0;
      check("prio_vs_eoi/lowest", 32'(lowest_prio), 32'd2);
      check("prio_vs_eoi/isr", 32'(isr), 32'h02);
      imr = '0; special_mask_mode = 0;

      // EOI clear and acknowledge set on the same bit: the set wins.
      pulse(8'h02);
      inta = 1; tick();
      inta = 0; tick();
      inta = 1; eoi_valid = 1; eoi_specific = 1; eoi_level = 3'd1; tick();
      inta = 0; eoi_valid = 0;
      check("eoi_vs_ack/ack_id", 32'(ack_id), 32'd1);
      check("eoi_vs_ack/isr", 32'(isr), 32'h02);

      // Request edge and acknowledge clear on the same bit: the edge is lost.
      pulse(8'h08);
      inta = 1; tick();
      inta = 0; tick();
      inta = 1; irq_in = 8'h08; tick();
      inta = 0;
      check("edge_vs_ack/ack_id", 32'(ack_id), 32'd3);
      check("edge_vs_ack/irr", 32'(irr), 32'h00);
      tick();
      check("edge_vs_ack/irr_later", 32'(irr), 32'h00);
      irq_in = '0; tick();
      check_model("directed_end");

      // Five channels: wrap past the top channel and out-of-range indices.
      sp_v5 = 1; sp_lvl5 = 3'd1; tick();
      check("n5/setprio1", 32'(low5), 32'd1);
      sp_lvl5 = 3'd4; tick();
      sp_v5 = 0;
      check("n5/setprio4", 32'(low5), 32'd4);
      irq5 = 5'h09; tick();
      irq5 = 5'h00; tick();
      check("n5/int_out", 32'(int5), 32'd1);
      inta5 = 1; tick();
      inta5 = 0; tick();
      inta5 = 1; tick();
      inta5 = 0;
      check("n5/ack_valid", 32'(ackv5), 32'd1);
      check("n5/ack_id_wrap", 32'(ack_id5), 32'd0);
      check("n5/isr", 32'(isr5), 32'h01);
      check("n5/irr", 32'(irr5), 32'h08);
      sp_v5 = 1; sp_lvl5 = 3'd7; tick();
      sp_v5 = 0;
      check("n5/setprio_oor", 32'(low5), 32'd4);
      eoi_v5 = 1; eoi_lvl5 = 3'd6; tick();
      eoi_v5 = 0;
      check("n5/eoi_oor", 32'(isr5), 32'h01);
      check("n5/blocked_int", 32'(int5), 32'd0);
      inta5 = 1; tick();
      inta5 = 0; tick();
      inta5 = 1; tick();
      inta5 = 0;
      check("n5/ack_id3", 32'(ack_id5), 32'd3);
      check("n5/isr2", 32'(isr5), 32'h09);

      // Random traffic against the reference model.
      for (int c = 0; c < 4000; c++) begin
         if (c % 500 == 0) begin
            level_mode        = ($urandom_range(0, 2) == 0);
            special_mask_mode = ($urandom_range(0, 1) == 1);
            auto_eoi          = ($urandom_range(0, 2) == 0);
            auto_rotate       = ($urandom_range(0, 1) == 1);
            imr               = 8'($urandom & $urandom & $urandom);
         end
         irq_in         = irq_in ^ 8'($urandom & $urandom & $urandom);
         inta           = ($urandom_range(0, 5) == 0);
         eoi_valid      = ($urandom_range(0, 7) == 0);
         eoi_specific   = ($urandom_range(0, 1) == 1);
         eoi_level      = 3'($urandom);
         eoi_rotate     = ($urandom_range(0, 3) == 0);
         set_prio_valid = ($urandom_range(0, 39) == 0);
         set_prio_level = 3'($urandom);
         tick();
         check_model($sformatf("rand%0d", c));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
